// File: rtl/sobel_pkg.sv
// Shared constants for the sobel window generator: default pixel width and 3x3 tap indices.
package sobel_pkg;

    localparam int PIXEL_W_DEF = 8;
    localparam int WIN_DIM     = 3;

    localparam int W_TL = 0;
    localparam int W_T  = 1;
    localparam int W_TR = 2;
    localparam int W_L  = 3;
    localparam int W_C  = 4;
    localparam int W_R  = 5;
    localparam int W_BL = 6;
    localparam int W_B  = 7;
    localparam int W_BR = 8;

    // Row-major tap index of window position (row, column).
    function automatic int win_idx(input int r, input int c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One raster line of pixels: single address, combinational read of the old word, write on the clock edge.
module sobel_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port; contents need no reset because the row count gates their use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster stream to 3x3 interior windows with valid/ready output stage.
// Optional SOBEL_WIN_COORD_EN adds win_x/win_y centre-coordinate outputs.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIXEL_W    = PIXEL_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [PIXEL_W-1:0] pixel_in,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] w0,
    output logic [PIXEL_W-1:0] w1,
    output logic [PIXEL_W-1:0] w2,
    output logic [PIXEL_W-1:0] w3,
    output logic [PIXEL_W-1:0] w4,
    output logic [PIXEL_W-1:0] w5,
    output logic [PIXEL_W-1:0] w6,
    output logic [PIXEL_W-1:0] w7,
    output logic [PIXEL_W-1:0] w8,
    output logic               frame_done
`ifdef SOBEL_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_ZERO = CW'(0);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_ZERO = RW'(0);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]      col_r, eff_col_s, col_nxt_s;
    logic [RW-1:0]      row_r, eff_row_s, row_nxt_s;
    logic               in_ready_s, accept_s, emit_s, last_s;
    logic               out_valid_r, frame_done_r;
    logic [PIXEL_W-1:0] lb0_rd_s, lb1_rd_s;
    logic [PIXEL_W-1:0] win_r [WIN_DIM*WIN_DIM];

    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;

    // Effective position of the incoming pixel (sof restarts the raster) and the following position.
    always_comb begin
        eff_col_s = col_r;
        eff_row_s = row_r;
        col_nxt_s = COL_ZERO;
        row_nxt_s = ROW_ZERO;
        if (in_sof) begin
            eff_col_s = COL_ZERO;
            eff_row_s = ROW_ZERO;
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end
        if (eff_col_s == COL_LAST) begin
            col_nxt_s = COL_ZERO;
            row_nxt_s = (eff_row_s == ROW_LAST) ? ROW_ZERO : eff_row_s + ROW_ONE;
        end else begin
            col_nxt_s = eff_col_s + COL_ONE;
            row_nxt_s = eff_row_s;
        end
        emit_s = accept_s && (eff_col_s >= COL_MIN) && (eff_row_s >= ROW_MIN);
        last_s = accept_s && (eff_col_s == COL_LAST) && (eff_row_s == ROW_LAST);
    end

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIXEL_W), .ADDR_W(CW)) u_lb0 (
        .clock   (clock),
        .wr_en   (accept_s),
        .addr    (eff_col_s),
        .wr_data (pixel_in),
        .rd_data (lb0_rd_s)
    );

    // lb1 is fed from lb0's old word, so it always holds the line two rows up.
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIXEL_W), .ADDR_W(CW)) u_lb1 (
        .clock   (clock),
        .wr_en   (accept_s),
        .addr    (eff_col_s),
        .wr_data (lb0_rd_s),
        .rd_data (lb1_rd_s)
    );

    // Raster position counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (accept_s) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // 3x3 window: shift left on every accept, new right column from the line buffers and the input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < WIN_DIM * WIN_DIM; i++) begin
                win_r[i] <= {PIXEL_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM - 1; c++) begin
                    win_r[win_idx(r, c)] <= win_r[win_idx(r, c + 1)];
                end
            end
            win_r[W_TR] <= lb1_rd_s;
            win_r[W_R]  <= lb0_rd_s;
            win_r[W_BR] <= pixel_in;
        end
    end

    // Output valid and end-of-frame pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= last_s;
            if (emit_s) begin
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef SOBEL_WIN_COORD_EN
    logic [CW-1:0] win_x_r;
    logic [RW-1:0] win_y_r;

    // Centre coordinate lags the newest pixel by one in each direction.
    always_ff @(posedge clock) begin
        if (!reset) begin
            win_x_r <= COL_ZERO;
            win_y_r <= ROW_ZERO;
        end else if (emit_s) begin
            win_x_r <= eff_col_s - COL_ONE;
            win_y_r <= eff_row_s - ROW_ONE;
        end
    end

    assign win_x = win_x_r;
    assign win_y = win_y_r;
`endif

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign w0 = win_r[W_TL];
    assign w1 = win_r[W_T];
    assign w2 = win_r[W_TR];
    assign w3 = win_r[W_L];
    assign w4 = win_r[W_C];
    assign w5 = win_r[W_R];
    assign w6 = win_r[W_BL];
    assign w7 = win_r[W_B];
    assign w8 = win_r[W_BR];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen on a 5x4 image: window scoreboard from an image-array model.
module tb_sobel_window_gen;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [PW-1:0] pixel_in = 8'd0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid, frame_done;
    logic [PW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
`ifdef SOBEL_WIN_COORD_EN
    logic [2:0]    win_x;
    logic [1:0]    win_y;
`endif

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .pixel_in   (pixel_in),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
        .frame_done (frame_done)
`ifdef SOBEL_WIN_COORD_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [71:0] pix;
        int          cx;
        int          cy;
    } win_t;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
    } stim_t;

    typedef struct {
        int cx;
        int cy;
        int w0;
        int w4;
        int w8;
    } vec_t;

    stim_t stim_q[$];
    win_t  exp_q[$];
    win_t  got_q[$];
    vec_t  tbl[6];

    int checks = 0;
    int passes = 0;
    int fd_count = 0;
    int fd_pix = -1;
    int exp_fd = 0;
    int exp_fd_pix = -1;
    int win_count = 0;
    int last_acc = -1;
    bit sb_en = 1'b0;

    logic [71:0] dut_win;
    assign dut_win = {w8, w7, w6, w5, w4, w3, w2, w1, w0};

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: frame_done timing and the window scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        win_t e;
        win_t g;
        if (reset) begin
            if (frame_done) begin
                fd_count++;
                fd_pix = last_acc;
            end
            if (in_valid && in_ready) last_acc = int'(pixel_in);
            if (out_valid && out_ready && sb_en) begin
                win_count++;
                g.pix = dut_win;
`ifdef SOBEL_WIN_COORD_EN
                g.cx = int'(win_x);
                g.cy = int'(win_y);
`else
                g.cx = -1;
                g.cy = -1;
`endif
                got_q.push_back(g);
                if (exp_q.size() == 0) begin
                    check("unexpected_window", dut_win, 72'd0 - 72'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("window", dut_win, e.pix);
`ifdef SOBEL_WIN_COORD_EN
                    check("win_x", 72'(win_x), 72'(e.cx));
                    check("win_y", 72'(win_y), 72'(e.cy));
`endif
                end
            end
        end
    end

    // Reference: place each pixel at its raster position and cut every full interior window.
    function automatic void build_expected();
        int img [H][W];
        int x = 0;
        int y = 0;
        win_t e;
        exp_q.delete();
        exp_fd = 0;
        exp_fd_pix = -1;
        foreach (stim_q[i]) begin
            if (stim_q[i].sof) begin
                x = 0;
                y = 0;
            end
            img[y][x] = int'(stim_q[i].pix);
            if (x >= 2 && y >= 2) begin
                for (int k = 0; k < 9; k++) e.pix[8*k +: 8] = 8'(img[y-2+k/3][x-2+k%3]);
                e.cx = x - 1;
                e.cy = y - 1;
                exp_q.push_back(e);
            end
            if (x == W-1 && y == H-1) begin
                exp_fd++;
                exp_fd_pix = int'(stim_q[i].pix);
            end
            x++;
            if (x == W) begin
                x = 0;
                y = (y == H-1) ? 0 : y + 1;
            end
        end
    endfunction

    task automatic add_pixels(input int base, input int count, input bit rnd);
        stim_t s;
        for (int i = 0; i < count; i++) begin
            s.pix = rnd ? 8'($urandom) : 8'(base + (i % W) + 10 * (i / W));
            s.sof = (i == 0);
            stim_q.push_back(s);
        end
    endtask

    task automatic drive(input int gap_pct, input int stall_win);
        int idx = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [71:0] held;
        while (idx < stim_q.size() && cyc < 2000) begin
            @(posedge clock); #1;
            cyc++;
            if (!stalled && stall_win >= 0 && win_count == stall_win && out_valid) begin
                stalled = 1'b1;
                out_ready = 1'b0;
                held = dut_win;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    check("stall_in_ready", 72'(in_ready), 72'd0);
                    check("stall_out_valid", 72'(out_valid), 72'd1);
                    check("stall_hold", dut_win, held);
                    @(posedge clock); #1;
                end
            end
            out_ready = 1'b1;
            in_valid = ($urandom_range(99) >= gap_pct);
            pixel_in = stim_q[idx].pix;
            in_sof = stim_q[idx].sof;
            @(negedge clock);
            if (in_valid && in_ready) idx++;
        end
        if (idx < stim_q.size()) check("drive_timeout", 72'(idx), 72'(stim_q.size()));
        if (stall_win >= 0) check("stall_happened", 72'(stalled), 72'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic run_test(input int gap_pct, input int stall_win);
        win_count = 0;
        fd_count = 0;
        fd_pix = -1;
        got_q.delete();
        build_expected();
        sb_en = 1'b1;
        drive(gap_pct, stall_win);
        sb_en = 1'b0;
        check("windows_missing", 72'(exp_q.size()), 72'd0);
        check("frame_done_count", 72'(fd_count), 72'(exp_fd));
        if (exp_fd > 0) check("frame_done_after_pixel", 72'(fd_pix), 72'(exp_fd_pix));
        stim_q.delete();
    endtask

    task automatic check_table(input int offset);
        check("table_count", 72'(got_q.size()), 72'd6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            check("table_w0", 72'(got_q[i].pix[7:0]), 72'(tbl[i].w0 + offset));
            check("table_w4", 72'(got_q[i].pix[39:32]), 72'(tbl[i].w4 + offset));
            check("table_w8", 72'(got_q[i].pix[71:64]), 72'(tbl[i].w8 + offset));
`ifdef SOBEL_WIN_COORD_EN
            check("table_win_x", 72'(got_q[i].cx), 72'(tbl[i].cx));
            check("table_win_y", 72'(got_q[i].cy), 72'(tbl[i].cy));
`endif
        end
    endtask

    initial begin
        int idx;
        int cyc;
        tbl[0] = '{1, 1, 0, 11, 22};
        tbl[1] = '{2, 1, 1, 12, 23};
        tbl[2] = '{3, 1, 2, 13, 24};
        tbl[3] = '{1, 2, 10, 21, 32};
        tbl[4] = '{2, 2, 11, 22, 33};
        tbl[5] = '{3, 2, 12, 23, 34};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", 72'(out_valid), 72'd0);
        check("rst_frame_done", 72'(frame_done), 72'd0);
        check("rst_window", dut_win, 72'd0);
        check("rst_in_ready", 72'(in_ready), 72'd1);
        reset = 1'b1;

        // Plain frame, no gaps
        add_pixels(0, W*H, 1'b0);
        run_test(0, -1);
        check_table(0);

        // Downstream stall at the third window
        add_pixels(0, W*H, 1'b0);
        run_test(0, 2);
        check_table(0);

        // Random input gaps
        add_pixels(0, W*H, 1'b0);
        run_test(50, -1);
        check_table(0);

        // sof mid-frame at (3,2): old frame abandoned, new frame complete
        add_pixels(0, 2*W + 3, 1'b0);
        add_pixels(100, W*H, 1'b0);
        run_test(0, -1);
        check("sof_total_windows", 72'(got_q.size()), 72'd7);
        got_q.delete(0);
        check_table(100);

        // Reset pulse while a window is pending
        add_pixels(0, W*H, 1'b0);
        idx = 0;
        cyc = 0;
        while (1) begin
            @(posedge clock); #1;
            if (out_valid || cyc > 100) break;
            in_valid = 1'b1;
            pixel_in = stim_q[idx].pix;
            in_sof = stim_q[idx].sof;
            @(negedge clock);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        check("rst5_reached_valid", 72'(out_valid), 72'd1);
        reset = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst5_out_valid", 72'(out_valid), 72'd0);
        check("rst5_frame_done", 72'(frame_done), 72'd0);
        check("rst5_window", dut_win, 72'd0);
        run_test(0, -1);
        check_table(0);

        // Random pixel values with gaps and a stall
        add_pixels(0, W*H, 1'b1);
        add_pixels(0, W*H, 1'b1);
        run_test(30, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
